// File: rtl/text_term_ctrl.sv
// Terminal controller: turns a byte stream into character-RAM writes and tracks
// the cursor, with CR/LF/BS/FF handling and wrap or circular scrolling.
module text_term_ctrl #(
    parameter int unsigned COLS   = 32,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COL_W  = 5,
    parameter int unsigned ROW_W  = 2,
    parameter bit          SCROLL = 1'b1,
    parameter logic [7:0]  FILL   = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic [ROW_W-1:0] top_row,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W:0]   ROWS_EXT = (ROW_W + 1)'(ROWS);

    localparam logic [7:0] BYTE_BS = 8'h08;
    localparam logic [7:0] BYTE_LF = 8'h0A;
    localparam logic [7:0] BYTE_FF = 8'h0C;
    localparam logic [7:0] BYTE_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ROW = 2'd1,
        CLR_ALL = 2'd2
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] cnt_row;
    logic [COL_W-1:0] cnt_col;

    logic [ROW_W:0]   row_sum;
    logic [ROW_W-1:0] prow;
    logic             is_print;
    logic             is_lf;
    logic             need_nl;

    assign in_ready = (state == IDLE);

    // Physical cursor row; explicit modulo so ROWS need not be a power of two
    always_comb begin
        row_sum  = {1'b0, cur_row} + {1'b0, top_row};
        prow     = (row_sum >= ROWS_EXT) ? ROW_W'(row_sum - ROWS_EXT) : row_sum[ROW_W-1:0];
        is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);
        is_lf    = (in_data == BYTE_LF);
        need_nl  = is_lf || (is_print && (cur_col == LAST_COL));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= '0;
            top_row <= '0;
            cur_row <= '0;
            cur_col <= '0;
            cnt_row <= '0;
            cnt_col <= '0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    // clr wins over a same-cycle byte, which stays unconsumed
                    if (clr || (in_valid && (in_data == BYTE_FF))) begin
                        state   <= CLR_ALL;
                        top_row <= '0;
                        cur_row <= '0;
                        cur_col <= '0;
                        cnt_row <= '0;
                        cnt_col <= '0;
                    end else if (in_valid) begin
                        if (is_print) begin
                            wr_en   <= 1'b1;
                            wr_row  <= prow;
                            wr_col  <= cur_col;
                            wr_data <= in_data;
                            cur_col <= (cur_col == LAST_COL) ? '0 : cur_col + 1'b1;
                        end else if ((in_data == BYTE_CR) || is_lf) begin
                            cur_col <= '0;
                        end else if ((in_data == BYTE_BS) && (cur_col != '0)) begin
                            wr_en   <= 1'b1;
                            wr_row  <= prow;
                            wr_col  <= cur_col - 1'b1;
                            wr_data <= FILL;
                            cur_col <= cur_col - 1'b1;
                        end

                        if (need_nl) begin
                            if (cur_row != LAST_ROW) begin
                                cur_row <= cur_row + 1'b1;
                            end else if (!SCROLL) begin
                                cur_row <= '0;
                            end else begin
                                // Old top row becomes the new bottom row and is blanked
                                top_row <= (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
                                cnt_row <= top_row;
                                cnt_col <= '0;
                                state   <= CLR_ROW;
                            end
                        end
                    end
                end

                CLR_ROW: begin
                    wr_en   <= 1'b1;
                    wr_row  <= cnt_row;
                    wr_col  <= cnt_col;
                    wr_data <= FILL;
                    if (cnt_col == LAST_COL) begin
                        state <= IDLE;
                    end else begin
                        cnt_col <= cnt_col + 1'b1;
                    end
                end

                CLR_ALL: begin
                    wr_en   <= 1'b1;
                    wr_row  <= cnt_row;
                    wr_col  <= cnt_col;
                    wr_data <= FILL;
                    if (cnt_col == LAST_COL) begin
                        cnt_col <= '0;
                        if (cnt_row == LAST_ROW) begin
                            state <= IDLE;
                        end else begin
                            cnt_row <= cnt_row + 1'b1;
                        end
                    end else begin
                        cnt_col <= cnt_col + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Directed bench for text_term_ctrl: table of single-byte vectors plus
// hand-written scroll, wrap, clear and reset-abort sequences.
module tb_text_term_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       clr;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;
    logic [1:0] top_row;
    logic [1:0] cur_row;
    logic [4:0] cur_col;

    logic       in_valid_w;
    logic [7:0] in_data_w;
    logic       in_ready_w;
    logic       clr_w;
    logic       wr_en_w;
    logic [1:0] wr_row_w;
    logic [4:0] wr_col_w;
    logic [7:0] wr_data_w;
    logic [1:0] top_row_w;
    logic [1:0] cur_row_w;
    logic [4:0] cur_col_w;

    int checks = 0;
    int errors = 0;

    text_term_ctrl #(.COLS(32), .ROWS(4), .COL_W(5), .ROW_W(2), .SCROLL(1'b1), .FILL(8'h20)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .clr(clr), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .top_row(top_row), .cur_row(cur_row), .cur_col(cur_col)
    );

    text_term_ctrl #(.COLS(32), .ROWS(4), .COL_W(5), .ROW_W(2), .SCROLL(1'b0), .FILL(8'h20)) u_wrap (
        .clk(clk), .reset(reset), .in_data(in_data_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .clr(clr_w), .wr_en(wr_en_w), .wr_row(wr_row_w), .wr_col(wr_col_w), .wr_data(wr_data_w),
        .top_row(top_row_w), .cur_row(cur_row_w), .cur_col(cur_col_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        logic       wr;
        logic [1:0] row;
        logic [4:0] col;
        logic [7:0] data;
        logic [1:0] crow;
        logic [4:0] ccol;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a byte from a negedge, return on the negedge after it is accepted
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck low for byte 0x%0h", b);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int  low_cnt;
        int  fills;
        int  ord_bad;
        bit  got_q;
        int  n;
        logic [7:0] bw;

        vecs[0]  = '{8'h41, 1'b1, 2'd0, 5'd0, 8'h41, 2'd0, 5'd1};
        vecs[1]  = '{8'h42, 1'b1, 2'd0, 5'd1, 8'h42, 2'd0, 5'd2};
        vecs[2]  = '{8'h0A, 1'b0, 2'd0, 5'd0, 8'h00, 2'd1, 5'd0};
        vecs[3]  = '{8'h68, 1'b1, 2'd1, 5'd0, 8'h68, 2'd1, 5'd1};
        vecs[4]  = '{8'h65, 1'b1, 2'd1, 5'd1, 8'h65, 2'd1, 5'd2};
        vecs[5]  = '{8'h6C, 1'b1, 2'd1, 5'd2, 8'h6C, 2'd1, 5'd3};
        vecs[6]  = '{8'h6C, 1'b1, 2'd1, 5'd3, 8'h6C, 2'd1, 5'd4};
        vecs[7]  = '{8'h6F, 1'b1, 2'd1, 5'd4, 8'h6F, 2'd1, 5'd5};
        vecs[8]  = '{8'h08, 1'b1, 2'd1, 5'd4, 8'h20, 2'd1, 5'd4};
        vecs[9]  = '{8'h0D, 1'b0, 2'd0, 5'd0, 8'h00, 2'd1, 5'd0};
        vecs[10] = '{8'h08, 1'b0, 2'd0, 5'd0, 8'h00, 2'd1, 5'd0};
        vecs[11] = '{8'h07, 1'b0, 2'd0, 5'd0, 8'h00, 2'd1, 5'd0};
        vecs[12] = '{8'h7F, 1'b0, 2'd0, 5'd0, 8'h00, 2'd1, 5'd0};
        vecs[13] = '{8'hC3, 1'b0, 2'd0, 5'd0, 8'h00, 2'd1, 5'd0};
        vecs[14] = '{8'h7E, 1'b1, 2'd1, 5'd0, 8'h7E, 2'd1, 5'd1};
        vecs[15] = '{8'h20, 1'b1, 2'd1, 5'd1, 8'h20, 2'd1, 5'd2};
        vecs[16] = '{8'h1F, 1'b0, 2'd0, 5'd0, 8'h00, 2'd1, 5'd2};

        reset = 1'b0;
        in_data = 8'h00; in_valid = 1'b0; clr = 1'b0;
        in_data_w = 8'h00; in_valid_w = 1'b0; clr_w = 1'b0;
        repeat (3) @(negedge clk);

        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_wr_addr", 32'({wr_row, wr_col, wr_data}), 32'd0);
        chk("reset_cursor", 32'({top_row, cur_row, cur_col}), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Wrap-mode instance: 128 printables fill the screen, cursor returns to (0,0)
        ord_bad = 0;
        n = 0;
        in_valid_w = 1'b1;
        in_data_w = 8'h30;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            bw = 8'h30 + 8'(i % 64);
            if (!wr_en_w || wr_row_w != 2'(i / 32) || wr_col_w != 5'(i % 32) || wr_data_w != bw) ord_bad++;
            if (cur_row_w != 2'(((i + 1) / 32) % 4) || cur_col_w != 5'((i + 1) % 32)) ord_bad++;
            if (wr_en_w) n++;
            in_data_w = 8'h30 + 8'((i + 1) % 64);
            if (i == 127) in_valid_w = 1'b0;
        end
        chk("wrap_sequence_errors", 32'(ord_bad), 32'd0);
        chk("wrap_write_count", 32'(n), 32'd128);
        chk("wrap_last_write", 32'({wr_row_w, wr_col_w}), 32'({2'd3, 5'd31}));
        chk("wrap_cursor", 32'({top_row_w, cur_row_w, cur_col_w}), 32'd0);
        @(negedge clk);
        chk("wrap_idle_no_write", 32'(wr_en_w), 32'd0);

        // Table-driven single bytes on the scrolling instance
        foreach (vecs[i]) begin
            send(vecs[i].b);
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].wr));
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_wr", i), 32'({wr_row, wr_col, wr_data}),
                    32'({vecs[i].row, vecs[i].col, vecs[i].data}));
            end
            chk($sformatf("v%0d_cursor", i), 32'({top_row, cur_row, cur_col}),
                32'({2'd0, vecs[i].crow, vecs[i].ccol}));
            @(negedge clk);
            chk($sformatf("v%0d_wr_pulse", i), 32'(wr_en), 32'd0);
        end

        // Fill to (3,31), then 'Z' triggers a scroll
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 31; i++) send(8'h61);
        chk("pre_scroll_cursor", 32'({top_row, cur_row, cur_col}), 32'({2'd0, 2'd3, 5'd31}));
        send(8'h5A);
        chk("scroll_char_write", 32'({wr_en, wr_row, wr_col, wr_data}), 32'({1'b1, 2'd3, 5'd31, 8'h5A}));
        chk("scroll_cursor", 32'({top_row, cur_row, cur_col}), 32'({2'd1, 2'd3, 5'd0}));
        low_cnt = 0;
        fills = 0;
        ord_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (!in_ready) low_cnt++;
            if (i > 0 && wr_en) begin
                if (wr_row != 2'd0 || wr_col != 5'(fills) || wr_data != 8'h20 || i != fills + 1) ord_bad++;
                fills++;
            end
            @(negedge clk);
        end
        chk("scroll_ready_low_cycles", 32'(low_cnt), 32'd32);
        chk("scroll_fill_count", 32'(fills), 32'd32);
        chk("scroll_fill_order", 32'(ord_bad), 32'd0);
        send(8'h59);
        chk("after_scroll_write", 32'({wr_en, wr_row, wr_col, wr_data}), 32'({1'b1, 2'd0, 5'd0, 8'h59}));
        chk("after_scroll_cursor", 32'({top_row, cur_row, cur_col}), 32'({2'd1, 2'd3, 5'd1}));

        // clr pulse with a simultaneous byte: byte waits until the clear finishes
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h51;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_ready_low", 32'(in_ready), 32'd0);
        chk("clr_cursor", 32'({top_row, cur_row, cur_col}), 32'd0);
        fills = 0;
        ord_bad = 0;
        got_q = 1'b0;
        for (int i = 0; i < 400 && !got_q; i++) begin
            @(negedge clk);
            if (wr_en && wr_data == 8'h20) begin
                if (wr_row != 2'(fills / 32) || wr_col != 5'(fills % 32)) ord_bad++;
                fills++;
            end else if (wr_en && wr_data == 8'h51) begin
                got_q = 1'b1;
                in_valid = 1'b0;
                chk("clr_q_addr", 32'({wr_row, wr_col}), 32'd0);
                chk("clr_q_after_fill", 32'(fills), 32'd128);
            end
        end
        in_valid = 1'b0;
        chk("clr_q_seen", 32'(got_q), 32'd1);
        chk("clr_fill_order", 32'(ord_bad), 32'd0);
        chk("clr_end_cursor", 32'({top_row, cur_row, cur_col}), 32'({2'd0, 2'd0, 5'd1}));
        @(negedge clk);

        // FF starts a full clear; reset midway aborts it
        send(8'h78);
        send(8'h0C);
        chk("ff_no_write", 32'(wr_en), 32'd0);
        chk("ff_ready_low", 32'(in_ready), 32'd0);
        chk("ff_cursor", 32'({top_row, cur_row, cur_col}), 32'd0);
        repeat (40) @(negedge clk);
        chk("ff_mid_clear_write", 32'({wr_en, wr_data}), 32'({1'b1, 8'h20}));
        #2 reset = 1'b0;
        #1;
        chk("abort_wr_en", 32'(wr_en), 32'd0);
        chk("abort_outputs", 32'({wr_row, wr_col, wr_data, top_row, cur_row, cur_col}), 32'd0);
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (wr_en) n++;
        end
        chk("abort_no_writes", 32'(n), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_ready_after", 32'(in_ready), 32'd1);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_en) n++;
        end
        chk("abort_stays_quiet", 32'(n), 32'd0);
        send(8'h52);
        chk("post_abort_write", 32'({wr_en, wr_row, wr_col, wr_data}), 32'({1'b1, 2'd0, 5'd0, 8'h52}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_term_ctrl.md
Name: text_term_ctrl

Overview:
Parametrised terminal controller between a byte source (UART receiver) and a dual-port character RAM read by the VGA text generator. It takes a valid/ready byte stream and tracks a cursor. It writes printable characters into the RAM and interprets CR, LF, BS and FF. On reaching the bottom of the screen it either wraps to the top or scrolls, using a circular top-row offset plus a hardware row clear.

Parameters:
COLS, 32, characters per row (≥2, need not be a power of two)
ROWS, 4, text rows (≥2)
COL_W, 5, column index width; COLS ≤ 2**COL_W
ROW_W, 2, row index width; ROWS ≤ 2**ROW_W
SCROLL, 1, 1 = scroll at bottom, 0 = wrap cursor to logical row 0 with no clear
FILL, 8'h20, byte written by clears and backspace

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-low reset
in_data  in  8  received byte
in_valid  in  1  byte available
in_ready  out  1  controller can accept; byte consumed when in_valid && in_ready at posedge
clr  in  1  clear-screen request, one-cycle pulse
wr_en  out  1  RAM write strobe, one cycle per write
wr_row  out  ROW_W  physical RAM row
wr_col  out  COL_W  RAM column
wr_data  out  8  RAM write data
top_row  out  ROW_W  physical row shown at screen top; display row = (screen row + top_row) mod ROWS
cur_row  out  ROW_W  logical cursor row (0 = top of screen)
cur_col  out  COL_W  cursor column

Behaviour:
- States: IDLE, CLR_ROW, CLR_ALL. in_ready = (state==IDLE), combinational.
- Reset (async, reset==0): state IDLE; wr_en, wr_row, wr_col, wr_data, top_row, cur_row, cur_col all 0. Reset mid-clear aborts the clear with no further writes.
- Physical cursor row: prow = (cur_row + top_row) mod ROWS, computed without relying on power-of-two wrap.
- Accept at edge k → wr_en high during cycle k+1 only (one-cycle latency). Cursor outputs update at edge k.
- Printable byte (0x20..0x7E): write {prow, cur_col, byte}. If cur_col < COLS-1, cur_col+1. Otherwise cur_col=0 and NEWLINE.
- CR 0x0D: cur_col=0, no write.
- LF 0x0A: cur_col=0, NEWLINE, no write.
- BS 0x08: if cur_col>0, cur_col−1 and write FILL at the new position. At cur_col==0 there is no action; no back-wrap to the previous row.
- FF 0x0C, or clr==1 in IDLE: enter CLR_ALL. clr has priority over a same-cycle in_valid, and that byte is not consumed (in_ready falls the next cycle).
- All other bytes (0x00..0x1F other than the above, 0x7F..0xFF): consumed, ignored.
- NEWLINE:
  - cur_row < ROWS-1: cur_row+1.
  - cur_row == ROWS-1, SCROLL=0: cur_row=0, no clear.
  - cur_row == ROWS-1, SCROLL=1: cur_row stays; top_row = (top_row+1) mod ROWS; enter CLR_ROW targeting the old top_row, which is the new bottom physical row.
- If a printable char triggers scrolling, its own write (old row, col COLS-1) issues at k+1. The first clear write follows at k+2.
- CLR_ROW: COLS consecutive cycles of wr_en=1, wr_data=FILL, fixed wr_row, wr_col 0..COLS-1 ascending. Back to IDLE after the last write; in_ready high the cycle after the last wr_en.
- CLR_ALL: ROWS*COLS consecutive writes of FILL, physical row 0..ROWS-1 outer, col 0..COLS-1 inner. top_row, cur_row, cur_col are set to 0 on entry. Back to IDLE after the last write.
- in_valid and clr are ignored while not IDLE. The source must hold in_valid.
- Total write counts: CLR_ROW exactly COLS; CLR_ALL exactly ROWS*COLS; never a write to col ≥ COLS or row ≥ ROWS.

Test Plan:
- Reset, send "AB" → writes (0,0,0x41), (0,1,0x42) each one cycle after accept; cur_col=2.
- COLS=32, ROWS=4, SCROLL=0: send 128 printables → last write at (3,31); cursor wraps to (0,0); top_row stays 0; no fill writes.
- SCROLL=1: fill to (3,31), then send 'Z' → 'Z' written at physical (3,31); top_row=1; 32 FILL writes to physical row 0 cols 0..31; in_ready low exactly 32 cycles; cur_row=3, cur_col=0.
- With cursor at (1,5) send BS → FILL written at (1,4), cur_col=4. Then CR, BS → no write, cursor (1,0).
- Pulse clr with simultaneous in_valid='Q' → 128 FILL writes in row-major order; 'Q' not consumed and accepted after the clear; cursor and top_row end at 0.
- Assert reset midway through CLR_ALL → wr_en drops immediately, all outputs 0, in_ready=1 after reset release.
